// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register and control stage, directly
// downstream of the alu block.
//   - Captures the alu results (R/zero) and EX-stage control, then hands the
//     beat to the memory stage over a valid/ready handshake.
//   - A taken branch produces a one-cycle redirect pulse. Its write controls
//     are cleared so the branch itself has no side effects in MEM.
//   - A signed overflow on a register-writing beat (with traps enabled) drops
//     the beat, pulses flush, raises exc_valid/exc_pc and holds until exc_ack.
//   - ovf_count is a saturating count of accepted beats that overflowed.
//
// Ports:
//   clk, reset (async, active-low)
//   ex_valid/ex_ready + alu_r/alu_zero/alu_ovf/alu_branch + ex_* : EX side
//   mem_valid/mem_ready + mem_*                                   : MEM side
//   redirect_valid/redirect_pc : branch redirect pulse and target
//   flush                      : front-end flush pulse on trap
//   exc_valid/exc_pc/exc_ack   : overflow exception handshake
//   ovf_count                  : saturating overflow counter
//
// state | meaning
// RUN   | normal flow, beats accepted when the MEM slot can take them
// TRAP  | overflow exception pending; EX blocked until exc_ack
module ex_mem_stage #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  input  logic             alu_branch,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [WIDTH-1:0] ex_br_target,
  input  logic [WIDTH-1:0] ex_store_data,
  input  logic [RD_W-1:0]  ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic             ex_memwrite,
  input  logic             ovf_trap_en,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] mem_alu_r,
  output logic             mem_zero,
  output logic [WIDTH-1:0] mem_store_data,
  output logic [RD_W-1:0]  mem_rd,
  output logic             mem_regwrite,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             flush,
  output logic             exc_valid,
  output logic [WIDTH-1:0] exc_pc,
  input  logic             exc_ack,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic {ST_RUN = 1'b0, ST_TRAP = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             mem_valid_q, mem_valid_d;
  logic [WIDTH-1:0] mem_alu_r_q, mem_alu_r_d;
  logic             mem_zero_q, mem_zero_d;
  logic [WIDTH-1:0] mem_store_data_q, mem_store_data_d;
  logic [RD_W-1:0]  mem_rd_q, mem_rd_d;
  logic             mem_regwrite_q, mem_regwrite_d;
  logic             mem_memread_q, mem_memread_d;
  logic             mem_memwrite_q, mem_memwrite_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic             flush_q, flush_d;
  logic             exc_valid_q, exc_valid_d;
  logic [WIDTH-1:0] exc_pc_q, exc_pc_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

  logic accept;
  logic trap;
  logic load;

  assign ex_ready = (state_q == ST_RUN) && (!mem_valid_q || mem_ready);
  assign accept   = ex_valid && ex_ready;
  assign trap     = accept && alu_ovf && ovf_trap_en && ex_regwrite;
  assign load     = accept && !trap;

  always_comb begin
    state_d          = state_q;
    mem_alu_r_d      = mem_alu_r_q;
    mem_zero_d       = mem_zero_q;
    mem_store_data_d = mem_store_data_q;
    mem_rd_d         = mem_rd_q;
    mem_regwrite_d   = mem_regwrite_q;
    mem_memread_d    = mem_memread_q;
    mem_memwrite_d   = mem_memwrite_q;
    redirect_pc_d    = redirect_pc_q;
    exc_valid_d      = exc_valid_q;
    exc_pc_d         = exc_pc_q;
    ovf_count_d      = ovf_count_q;

    // A new load replaces a draining beat in the same cycle (no bubble).
    mem_valid_d      = load || (mem_valid_q && !mem_ready);
    redirect_valid_d = load && alu_branch;
    flush_d          = trap;

    if (load) begin
      mem_alu_r_d      = alu_r;
      mem_zero_d       = alu_zero;
      mem_store_data_d = ex_store_data;
      mem_rd_d         = ex_rd;
      mem_regwrite_d   = ex_regwrite && !alu_branch;
      mem_memread_d    = ex_memread  && !alu_branch;
      mem_memwrite_d   = ex_memwrite && !alu_branch;
      if (alu_branch) begin
        redirect_pc_d = ex_br_target;
      end
    end

    case (state_q)
      ST_RUN: begin
        if (trap) begin
          state_d     = ST_TRAP;
          exc_valid_d = 1'b1;
          exc_pc_d    = ex_pc;
        end
      end
      ST_TRAP: begin
        if (exc_ack) begin
          state_d     = ST_RUN;
          exc_valid_d = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (accept && alu_ovf && (ovf_count_q != {CNT_W{1'b1}})) begin
      ovf_count_d = ovf_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_RUN;
      mem_valid_q      <= 1'b0;
      mem_alu_r_q      <= '0;
      mem_zero_q       <= 1'b0;
      mem_store_data_q <= '0;
      mem_rd_q         <= '0;
      mem_regwrite_q   <= 1'b0;
      mem_memread_q    <= 1'b0;
      mem_memwrite_q   <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      exc_valid_q      <= 1'b0;
      exc_pc_q         <= '0;
      ovf_count_q      <= '0;
    end else begin
      state_q          <= state_d;
      mem_valid_q      <= mem_valid_d;
      mem_alu_r_q      <= mem_alu_r_d;
      mem_zero_q       <= mem_zero_d;
      mem_store_data_q <= mem_store_data_d;
      mem_rd_q         <= mem_rd_d;
      mem_regwrite_q   <= mem_regwrite_d;
      mem_memread_q    <= mem_memread_d;
      mem_memwrite_q   <= mem_memwrite_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      exc_valid_q      <= exc_valid_d;
      exc_pc_q         <= exc_pc_d;
      ovf_count_q      <= ovf_count_d;
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_alu_r      = mem_alu_r_q;
  assign mem_zero       = mem_zero_q;
  assign mem_store_data = mem_store_data_q;
  assign mem_rd         = mem_rd_q;
  assign mem_regwrite   = mem_regwrite_q;
  assign mem_memread    = mem_memread_q;
  assign mem_memwrite   = mem_memwrite_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign exc_valid      = exc_valid_q;
  assign exc_pc         = exc_pc_q;
  assign ovf_count      = ovf_count_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios followed by random traffic.
// Driver drives at posedge+1 and updates a transaction-level model; MEM beats
// are pushed into a scoreboard queue and popped by an independent monitor
// whenever the DUT completes a valid/ready transfer.
module tb_ex_mem_stage;
  localparam int WIDTH   = 32;
  localparam int RD_W    = 5;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             ex_valid = 1'b0;
  logic             ex_ready;
  logic [WIDTH-1:0] alu_r = '0;
  logic             alu_zero = 1'b0;
  logic             alu_ovf = 1'b0;
  logic             alu_branch = 1'b0;
  logic [WIDTH-1:0] ex_pc = '0;
  logic [WIDTH-1:0] ex_br_target = '0;
  logic [WIDTH-1:0] ex_store_data = '0;
  logic [RD_W-1:0]  ex_rd = '0;
  logic             ex_regwrite = 1'b0;
  logic             ex_memread = 1'b0;
  logic             ex_memwrite = 1'b0;
  logic             ovf_trap_en = 1'b0;
  logic             mem_valid;
  logic             mem_ready = 1'b0;
  logic [WIDTH-1:0] mem_alu_r;
  logic             mem_zero;
  logic [WIDTH-1:0] mem_store_data;
  logic [RD_W-1:0]  mem_rd;
  logic             mem_regwrite;
  logic             mem_memread;
  logic             mem_memwrite;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             flush;
  logic             exc_valid;
  logic [WIDTH-1:0] exc_pc;
  logic             exc_ack = 1'b0;
  logic [CNT_W-1:0] ovf_count;

  ex_mem_stage #(.WIDTH(WIDTH), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_branch(alu_branch),
    .ex_pc(ex_pc), .ex_br_target(ex_br_target), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ovf_trap_en(ovf_trap_en),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_alu_r(mem_alu_r), .mem_zero(mem_zero), .mem_store_data(mem_store_data),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_ack(exc_ack),
    .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             zero;
    logic [WIDTH-1:0] sd;
    logic [RD_W-1:0]  rd;
    logic             rw;
    logic             mr;
    logic             mw;
  } beat_t;

  beat_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  // Transaction-level model state
  bit         m_full, m_trap;
  bit         e_flush, e_redir_v, e_exc_v;
  logic [31:0] e_redir_pc, e_exc_pc;
  int         e_cnt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer is visible at negedge and completes at the next posedge.
  always @(negedge clk) begin
    if (reset && mem_valid && mem_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 128'(sb.size()), 128'd1);
      end else begin
        beat_t b;
        beat_t a;
        b = sb.pop_front();
        a = '{r: mem_alu_r, zero: mem_zero, sd: mem_store_data, rd: mem_rd,
              rw: mem_regwrite, mr: mem_memread, mw: mem_memwrite};
        chk("mem_beat", 128'(a), 128'(b));
      end
    end
  end

  task automatic idle();
    ex_valid = 1'b0; alu_ovf = 1'b0; alu_branch = 1'b0; exc_ack = 1'b0;
  endtask

  task automatic set_beat(input logic [31:0] r, input bit ovf, input bit br,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input bit rw, input bit en);
    ex_valid = 1'b1; alu_r = r; alu_zero = (r == 0); alu_ovf = ovf; alu_branch = br;
    ex_pc = pc; ex_br_target = tgt; ex_store_data = r ^ 32'hA5A5_0000;
    ex_rd = RD_W'(pc[6:2]); ex_regwrite = rw; ex_memread = 1'b0; ex_memwrite = ~rw;
    ovf_trap_en = en;
  endtask

  // One clock: called at posedge+1 with inputs already driven.
  task automatic step();
    bit rdy, acc, trp, ld;
    #1;
    rdy = !m_trap && (!m_full || mem_ready);
    chk("ex_ready", 128'(ex_ready), 128'(rdy));
    acc = ex_valid && rdy;
    trp = acc && alu_ovf && ovf_trap_en && ex_regwrite;
    ld  = acc && !trp;
    if (ld) begin
      beat_t b;
      b.r = alu_r; b.zero = alu_zero; b.sd = ex_store_data; b.rd = ex_rd;
      b.rw = alu_branch ? 1'b0 : ex_regwrite;
      b.mr = alu_branch ? 1'b0 : ex_memread;
      b.mw = alu_branch ? 1'b0 : ex_memwrite;
      sb.push_back(b);
    end
    if (acc && alu_ovf && e_cnt < CNT_MAX) e_cnt++;
    e_flush   = trp;
    e_redir_v = ld && alu_branch;
    if (e_redir_v) e_redir_pc = ex_br_target;
    if (trp) begin
      m_trap = 1'b1;
      e_exc_pc = ex_pc;
    end else if (m_trap && exc_ack) begin
      m_trap = 1'b0;
    end
    e_exc_v = m_trap;
    m_full = ld ? 1'b1 : (mem_ready ? 1'b0 : m_full);
    @(posedge clk);
    #1;
    chk("mem_valid", 128'(mem_valid), 128'(m_full));
    chk("flush", 128'(flush), 128'(e_flush));
    chk("redirect_valid", 128'(redirect_valid), 128'(e_redir_v));
    chk("redirect_pc", 128'(redirect_pc), 128'(e_redir_pc));
    chk("exc_valid", 128'(exc_valid), 128'(e_exc_v));
    chk("exc_pc", 128'(exc_pc), 128'(e_exc_pc));
    chk("ovf_count", 128'(ovf_count), 128'(e_cnt));
  endtask

  // Asynchronous reset taken between edges; all held state is discarded.
  task automatic do_reset();
    reset = 1'b0;
    idle();
    #2;
    chk("rst_outputs",
        128'({mem_valid, mem_alu_r, mem_zero, mem_rd, mem_regwrite, mem_memread,
              mem_memwrite, redirect_valid, flush, exc_valid, ovf_count}), 128'd0);
    chk("rst_words", 128'({mem_store_data, redirect_pc, exc_pc}), 128'd0);
    sb.delete();
    m_full = 0; m_trap = 0; e_flush = 0; e_redir_v = 0; e_exc_v = 0;
    e_redir_pc = '0; e_exc_pc = '0; e_cnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    do_reset();

    // Back-to-back adds with no bubble
    mem_ready = 1'b1;
    set_beat(32'h5, 0, 0, 32'h10, 32'h0, 1, 0); step();
    chk("b2b_first", 128'(mem_alu_r), 128'h5);
    set_beat(32'hA, 0, 0, 32'h14, 32'h0, 1, 0); step();
    chk("b2b_second", 128'(mem_alu_r), 128'hA);

    // Backpressure: 3 stalled cycles, then the waiting beat enters
    mem_ready = 1'b0;
    set_beat(32'h77, 0, 0, 32'h18, 32'h0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_r", 128'(mem_alu_r), 128'hA);
    end
    mem_ready = 1'b1; step();
    chk("bp_enter", 128'(mem_alu_r), 128'h77);

    // Taken branch with regwrite set
    set_beat(32'h3, 0, 1, 32'h1C, 32'h40, 1, 0); step();
    chk("br_redirect", 128'({redirect_valid, redirect_pc, mem_regwrite}), 128'({1'b1, 32'h40, 1'b0}));
    idle(); step();
    chk("br_pulse_end", 128'({redirect_valid, redirect_pc}), 128'({1'b0, 32'h40}));

    // Overflow trap on a branch beat: trap wins
    set_beat(32'h9, 1, 1, 32'h100, 32'h80, 1, 1); step();
    chk("trap", 128'({flush, exc_valid, exc_pc, redirect_valid, ovf_count}),
        128'({1'b1, 1'b1, 32'h100, 1'b0, 2'd1}));
    set_beat(32'h55, 0, 0, 32'h104, 32'h0, 1, 0);
    for (int i = 0; i < 3; i++) step();
    exc_ack = 1'b1; step();
    exc_ack = 1'b0; step();
    exc_ack = 1'b1; step();   // ack in RUN is ignored
    exc_ack = 1'b0;

    // Reset with a beat held in MEM
    mem_ready = 1'b0;
    set_beat(32'h33, 0, 0, 32'h20, 32'h0, 1, 0); step();
    do_reset();

    // Untrapped overflow saturation
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_beat(32'h1000 + i, 1, 0, 32'h200 + 4 * i, 32'h0, 1, 0); step();
    end
    chk("sat_count", 128'(ovf_count), 128'd3);

    // Reset while trapped
    do_reset();
    set_beat(32'h1, 1, 0, 32'h300, 32'h0, 1, 1); step();
    idle(); step();
    do_reset();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      ex_valid      = ($urandom % 4) != 0;
      alu_r         = $urandom;
      alu_zero      = $urandom % 2;
      alu_ovf       = ($urandom % 4) == 0;
      alu_branch    = ($urandom % 4) == 0;
      ex_pc         = $urandom;
      ex_br_target  = $urandom;
      ex_store_data = $urandom;
      ex_rd         = RD_W'($urandom);
      ex_regwrite   = $urandom % 2;
      ex_memread    = $urandom % 2;
      ex_memwrite   = $urandom % 2;
      ovf_trap_en   = $urandom % 2;
      mem_ready     = ($urandom % 3) != 0;
      exc_ack       = ($urandom % 3) == 0;
      step();
    end

    // Drain and confirm every issued beat came out
    idle(); mem_ready = 1'b1; exc_ack = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("sb_empty", 128'(sb.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
